// File: rtl/morse_frame_receiver.sv
// Morse frame receiver: samples the serial line on each unit strobe, re-frames it into
// fixed-width letter frames, reverse-maps each frame to a 5-bit letter code and queues
// results in a small valid/ready FIFO.
module morse_frame_receiver #(
  parameter int unsigned FRAME_BITS = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] out_letter,
  output logic       out_error,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned SlotW = $clog2(FRAME_BITS + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [SlotW-1:0] LastSlot = SlotW'(FRAME_BITS - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  frame_q;
  logic [SlotW-1:0]       slot_q;
  logic                   done_q;
  logic                   busy_q;

  logic [4:0]             dec_letter;
  logic                   dec_error;

  logic [5:0]             mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   overflow_q;

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   push_ok;

  // Frame collection FSM; idle filler zeros are skipped, a mark starts a new frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      frame_q <= '0;
      slot_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (enable) begin
        unique case (state_q)
          StIdle: begin
            if (in) begin
              frame_q <= FRAME_BITS'(1);
              slot_q  <= SlotW'(1);
              state_q <= StCollect;
              busy_q  <= 1'b1;
            end
          end
          StCollect: begin
            // First sampled bit shifts up to the MSB.
            frame_q <= {frame_q[FRAME_BITS-2:0], in};
            if (slot_q == LastSlot) begin
              slot_q  <= '0;
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Exact-match reverse lookup of the completed frame; anything else is an error entry.
  always_comb begin
    dec_letter = 5'd31;
    case (frame_q)
      14'b10111000000000: dec_letter = 5'd0;
      14'b11101010100000: dec_letter = 5'd1;
      14'b11101011101000: dec_letter = 5'd2;
      14'b11101010000000: dec_letter = 5'd3;
      14'b10000000000000: dec_letter = 5'd4;
      14'b10101110100000: dec_letter = 5'd5;
      14'b11101110100000: dec_letter = 5'd6;
      14'b10101010000000: dec_letter = 5'd7;
      14'b10100000000000: dec_letter = 5'd8;
      14'b10111011101110: dec_letter = 5'd9;
      14'b11101011100000: dec_letter = 5'd10;
      14'b10111010100000: dec_letter = 5'd11;
      14'b11101110000000: dec_letter = 5'd12;
      14'b11101000000000: dec_letter = 5'd13;
      14'b11101110111000: dec_letter = 5'd14;
      14'b10111011101000: dec_letter = 5'd15;
      14'b11101110101110: dec_letter = 5'd16;
      14'b10111010000000: dec_letter = 5'd17;
      14'b10101000000000: dec_letter = 5'd18;
      14'b11100000000000: dec_letter = 5'd19;
      14'b10101110000000: dec_letter = 5'd20;
      14'b10101011100000: dec_letter = 5'd21;
      14'b10111011100000: dec_letter = 5'd22;
      14'b11101010111000: dec_letter = 5'd23;
      14'b11101011101110: dec_letter = 5'd24;
      14'b11101110101000: dec_letter = 5'd25;
      default:            dec_letter = 5'd31;
    endcase
    // No real letter uses code 31, so it doubles as the no-match marker.
    dec_error = (dec_letter == 5'd31);
  end

  assign push    = done_q;
  assign pop     = (count_q != '0) & out_ready;
  assign full    = (count_q == FullCnt);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push & full & ~pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents only matter while occupancy covers them.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {dec_error, dec_letter};
    end
  end

  assign out_valid  = (count_q != '0);
  // Gated so the head reads as zero while empty, including straight out of reset.
  assign out_letter = out_valid ? mem_q[rd_ptr_q][4:0] : 5'd0;
  assign out_error  = out_valid ? mem_q[rd_ptr_q][5] : 1'b0;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_frame_receiver.sv
// Self-checking bench for morse_frame_receiver: directed scenarios plus a randomized
// pass over every letter, checked against a table-search reference model.
module tb_morse_frame_receiver;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       line_in;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] out_letter;
  logic       out_error;
  logic       busy;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [13:0] pats [26];
  logic [5:0]  got [$];

  morse_frame_receiver #(
    .FRAME_BITS(14),
    .FIFO_DEPTH(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in        (line_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_letter(out_letter),
    .out_error (out_error),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial forever #5 clock = ~clock;

  // Record every handshake, sampled mid-low-phase when inputs and outputs are settled.
  always @(negedge clock) begin
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back({out_error, out_letter});
  end

  // Reference: linear search of the letter table; no match gives the error entry.
  function automatic logic [5:0] model_decode(input logic [13:0] f);
    for (int i = 0; i < 26; i++) begin
      if (pats[i] == f) return {1'b0, 5'(i)};
    end
    return {1'b1, 5'd31};
  endfunction

  // One unit slot: enable strobe for one clock, then three idle clocks.
  task automatic send_slot(input logic b, input bit ready_pulse, output logic busy_after);
    @(negedge clock);
    line_in = b;
    enable  = 1'b1;
    @(negedge clock);
    enable     = 1'b0;
    line_in    = 1'b0;
    busy_after = busy;
    if (ready_pulse) out_ready = 1'b1;
    @(negedge clock);
    if (ready_pulse) out_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_frame(input logic [13:0] f, input bit ready_pulse_last);
    logic b;
    for (int i = 13; i >= 0; i--) send_slot(f[i], (ready_pulse_last && i == 0), b);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; line_in = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    checks++; if (out_letter !== 5'd0) begin errors++; $display("FAIL rst_letter got=%0d want=0", out_letter); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b want=0", out_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b want=0", overflow); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int   nbusy = 0;
    logic b;
    out_ready = 1'b1;
    got.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_pre got=%b want=0", busy); end
    for (int i = 13; i >= 1; i--) begin
      send_slot(pats[0][i], 1'b0, b);
      if (b === 1'b1) nbusy++;
    end
    // Final slot done by hand to observe the push latency.
    @(negedge clock);
    line_in = pats[0][0];
    enable  = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    if (busy === 1'b1) nbusy++;
    checks++; if (nbusy !== 13) begin errors++; $display("FAIL single_busy_span got=%0d want=13", nbusy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got=%b want=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b want=0", out_valid); end
    @(negedge clock);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_lat got=%b want=1", out_valid); end
    checks++; if ({out_error, out_letter} !== model_decode(pats[0])) begin
      errors++; $display("FAIL single_head got=%h want=%h", {out_error, out_letter}, model_decode(pats[0]));
    end
    repeat (3) @(negedge clock);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL single_count got=%0d want=1", got.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic       b;
    logic [5:0] exp_q [$];
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 20; i++) send_slot(1'b0, 1'b0, b);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL b2b_filler got=%0d want=0", got.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_filler_busy got=%b want=0", busy); end
    send_frame(pats[9], 1'b0);
    send_frame(pats[0], 1'b0);
    exp_q.push_back(model_decode(pats[9]));
    exp_q.push_back(model_decode(pats[0]));
    repeat (6) @(negedge clock);
    checks++; if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got=%0d want=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_entry%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 6'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [13:0] bad = 14'h3FFF;
    logic [5:0]  exp_q [$];
    out_ready = 1'b1;
    got.delete();
    send_frame(bad, 1'b0);
    send_frame(pats[4], 1'b0);
    exp_q.push_back(model_decode(bad));
    exp_q.push_back(model_decode(pats[4]));
    repeat (6) @(negedge clock);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL inv_count got=%0d want=2", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        errors++; $display("FAIL inv_entry%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 6'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int         word [5] = '{7, 4, 11, 11, 14};
    logic [5:0] exp_q [$];
    logic       exp_ovf = 1'b0;
    out_ready = 1'b0;
    got.delete();
    foreach (word[k]) begin
      send_frame(pats[word[k]], 1'b0);
      if (exp_q.size() < 4) exp_q.push_back(model_decode(pats[word[k]]));
      else exp_ovf = 1'b1;
    end
    repeat (4) @(negedge clock);
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL bp_overflow got=%b want=%b", overflow, exp_ovf); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b want=1", out_valid); end
    checks++; if ({out_error, out_letter} !== exp_q[0]) begin
      errors++; $display("FAIL bp_head got=%h want=%h", {out_error, out_letter}, exp_q[0]);
    end
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    checks++; if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count got=%0d want=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_entry%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 6'hxx, exp_q[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky got=%b want=1", overflow); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [5:0]  exp_q [$];
    logic [13:0] f;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    out_ready = 1'b0;
    got.delete();
    for (int k = 0; k < 5; k++) begin
      f = pats[$urandom_range(0, 25)];
      exp_q.push_back(model_decode(f));
      // Last frame completes while full; ready is raised only for its push cycle.
      send_frame(f, (k == 4));
    end
    repeat (2) @(negedge clock);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b want=0", overflow); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL fpp_popped got=%0d want=1", got.size()); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fpp_valid got=%b want=1", out_valid); end
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    checks++; if (got.size() != 5) begin errors++; $display("FAIL fpp_count got=%0d want=5", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        errors++; $display("FAIL fpp_entry%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 6'hxx, exp_q[i]);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow_end got=%b want=0", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    logic b;
    out_ready = 1'b0;
    got.delete();
    send_frame(pats[4], 1'b0);
    for (int i = 13; i >= 8; i--) send_slot(pats[16][i], 1'b0, b);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rmf_pre got=busy%b/valid%b want=1/1", busy, out_valid);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy got=%b want=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid got=%b want=0", out_valid); end
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    send_frame(pats[19], 1'b0);
    repeat (6) @(negedge clock);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL rmf_count got=%0d want=1", got.size()); end
    checks++; if (got.size() < 1 || got[0] !== model_decode(pats[19])) begin
      errors++; $display("FAIL rmf_entry got=%h want=%h", (got.size() > 0) ? got[0] : 6'hxx, model_decode(pats[19]));
    end
  endtask

  task automatic test_random_letters();
    int          order [26];
    int          j;
    int          t;
    logic        b;
    logic [13:0] frames [$];
    logic [13:0] f;
    logic [5:0]  exp_q [$];
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 26; i++) order[i] = i;
    for (int i = 25; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 26; i++) frames.push_back(pats[order[i]]);
    for (int k = 0; k < 3; k++) begin
      f = {1'b1, 13'($urandom)};
      frames.insert($urandom_range(0, frames.size()), f);
    end
    foreach (frames[k]) begin
      repeat ($urandom_range(0, 2)) send_slot(1'b0, 1'b0, b);
      send_frame(frames[k], 1'b0);
      exp_q.push_back(model_decode(frames[k]));
    end
    repeat (6) @(negedge clock);
    checks++; if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_count got=%0d want=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        errors++; $display("FAIL rnd_entry%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 6'hxx, exp_q[i]);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rnd_overflow got=%b want=0", overflow); end
  endtask

  initial begin
    pats = '{14'b10111000000000, 14'b11101010100000, 14'b11101011101000, 14'b11101010000000,
             14'b10000000000000, 14'b10101110100000, 14'b11101110100000, 14'b10101010000000,
             14'b10100000000000, 14'b10111011101110, 14'b11101011100000, 14'b10111010100000,
             14'b11101110000000, 14'b11101000000000, 14'b11101110111000, 14'b10111011101000,
             14'b11101110101110, 14'b10111010000000, 14'b10101000000000, 14'b11100000000000,
             14'b10101110000000, 14'b10101011100000, 14'b10111011100000, 14'b11101010111000,
             14'b11101011101110, 14'b11101110101000};
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid_frame();
    test_random_letters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
